// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 16-word synchronous-read instruction memory: owns the PC,
// hides the one-cycle read latency, and arbitrates program download against fetch.
module instr_fetch_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 16,
  parameter bit HALT_ON_NOP = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              run_i,
  input  logic              ld_req_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_data_i,
  output logic              ld_ack_o,
  input  logic              br_valid_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              ir_valid_o,
  input  logic              ir_ready_i,
  output logic [DATA_W-1:0] ir_o,
  output logic [ADDR_W-1:0] ir_pc_o,
  output logic              halted_o,
  output logic              mem_wren_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_din_o,
  input  logic [DATA_W-1:0] mem_q_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_HALT,
    S_LOAD
  } state_e;

  state_e              state_q, state_d;
  state_e              ret_q, ret_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [ADDR_W-1:0]   ir_pc_q, ir_pc_d;
  logic                ir_valid_q, ir_valid_d;
  logic                halted_q, halted_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      halted_q   <= halted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    halted_d   = halted_q;

    unique case (state_q)
      S_IDLE: begin
        if (ld_req_i) begin
          state_d = S_LOAD;
          ret_d   = S_IDLE;
        end else if (br_valid_i) begin
          pc_d = br_target_i;
        end else if (run_i) begin
          state_d = S_ISSUE;
        end
      end

      S_ISSUE, S_WAIT, S_HOLD: begin
        // A redirect or a stop discards whatever is in flight; the PC alone
        // records where fetch resumes.
        if (br_valid_i) begin
          pc_d       = br_target_i;
          ir_valid_d = 1'b0;
          state_d    = S_ISSUE;
        end else if (!run_i) begin
          ir_valid_d = 1'b0;
          state_d    = S_IDLE;
        end else if (state_q == S_ISSUE) begin
          state_d = S_WAIT;
        end else if (state_q == S_WAIT) begin
          if (HALT_ON_NOP && (mem_q_i == '0)) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            ir_d       = mem_q_i;
            ir_pc_d    = pc_q;
            ir_valid_d = 1'b1;
            state_d    = S_HOLD;
          end
        end else if (ir_ready_i) begin
          ir_valid_d = 1'b0;
          pc_d       = pc_q + ADDR_W'(1);
          state_d    = S_ISSUE;
        end
      end

      S_HALT: begin
        // Redirect beats a pending load; the loader keeps its request up and is served later.
        if (br_valid_i) begin
          pc_d     = br_target_i;
          halted_d = 1'b0;
          state_d  = S_ISSUE;
        end else if (ld_req_i) begin
          state_d = S_LOAD;
          ret_d   = S_HALT;
        end else if (!run_i) begin
          halted_d = 1'b0;
          state_d  = S_IDLE;
        end
      end

      S_LOAD: begin
        state_d = ret_q;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mem_wren_o    = (state_q == S_LOAD);
  assign ld_ack_o      = (state_q == S_LOAD);
  assign mem_address_o = (state_q == S_LOAD) ? ld_addr_i : pc_q;
  assign mem_din_o     = ld_data_i;
  assign ir_valid_o    = ir_valid_q;
  assign ir_o          = ir_q;
  assign ir_pc_o       = ir_pc_q;
  assign halted_o      = halted_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a cycle table for download and straight-line fetch,
// hand sequences for the multi-cycle corners, then randomized fetch against a PC/memory model.
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        ld_req = 1'b0;
  logic [3:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ack;
  logic        br = 1'b0;
  logic [3:0]  br_tgt = '0;
  logic        ir_valid;
  logic        rdy = 1'b0;
  logic [15:0] ir;
  logic [3:0]  ir_pc;
  logic        halted;
  logic        mem_wren;
  logic [3:0]  mem_address;
  logic [15:0] mem_din;
  logic [15:0] mem_q;

  logic [15:0] mem [16];
  logic [15:0] ref_mem [16];

  int passed = 0;
  int total  = 0;

  instr_fetch_ctrl #(.ADDR_W(4), .DATA_W(16), .HALT_ON_NOP(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .run_i(run),
    .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ack_o(ld_ack),
    .br_valid_i(br), .br_target_i(br_tgt),
    .ir_valid_o(ir_valid), .ir_ready_i(rdy), .ir_o(ir), .ir_pc_o(ir_pc),
    .halted_o(halted),
    .mem_wren_o(mem_wren), .mem_address_o(mem_address), .mem_din_o(mem_din),
    .mem_q_i(mem_q)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory: Q shows the word addressed at the previous edge.
  always @(posedge clk) begin
    if (mem_wren) mem[mem_address] <= mem_din;
    mem_q <= mem[mem_address];
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic        run;
    logic        ld_req;
    logic [3:0]  ld_addr;
    logic [15:0] ld_data;
    logic        br;
    logic [3:0]  br_tgt;
    logic        rdy;
    logic        ack;
    logic        wren;
    logic [3:0]  addr;
    logic        ivld;
    logic [15:0] ir;
    logic [3:0]  irpc;
    logic        halted;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ir_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk("ir_valid_within_bound", 32'(ok), 32'(1));
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    bit got;
    got = 1'b0;
    ld_req  = 1'b1;
    ld_addr = a;
    ld_data = d;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (ld_ack) begin
        got = 1'b1;
        chk("load_wren", 32'(mem_wren), 32'(1));
        chk("load_addr", 32'(mem_address), 32'(a));
      end
      @(posedge clk);
      #1;
    end
    ld_req = 1'b0;
    chk("load_ack_seen", 32'(got), 32'(1));
    @(negedge clk);
    chk("load_ack_once", 32'(ld_ack), 32'(0));
    @(posedge clk);
    #1;
    ref_mem[a] = d;
  endtask

  initial begin
    bit          ok;
    logic [3:0]  exp_pc;
    int          accepts;
    logic [27:0] got_o, exp_o;

    //            run ldr addr  data      br tgt rdy | ack wren addr ivld ir       irpc hlt
    vecs[0]  = '{1'b0,1'b1,4'd0,16'h8882,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[1]  = '{1'b0,1'b1,4'd0,16'h8882,1'b0,4'd0,1'b0, 1'b1,1'b1,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[2]  = '{1'b0,1'b1,4'd1,16'hA081,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[3]  = '{1'b0,1'b1,4'd1,16'hA081,1'b0,4'd0,1'b0, 1'b1,1'b1,4'd1,1'b0,16'h0000,4'd0,1'b0};
    vecs[4]  = '{1'b0,1'b1,4'd2,16'h40A0,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[5]  = '{1'b0,1'b1,4'd2,16'h40A0,1'b0,4'd0,1'b0, 1'b1,1'b1,4'd2,1'b0,16'h0000,4'd0,1'b0};
    vecs[6]  = '{1'b0,1'b1,4'd3,16'h0000,1'b0,4'd0,1'b0, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[7]  = '{1'b0,1'b1,4'd3,16'h0000,1'b0,4'd0,1'b0, 1'b1,1'b1,4'd3,1'b0,16'h0000,4'd0,1'b0};
    vecs[8]  = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[9]  = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[10] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b0,16'h0000,4'd0,1'b0};
    vecs[11] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd0,1'b1,16'h8882,4'd0,1'b0};
    vecs[12] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd1,1'b0,16'h8882,4'd0,1'b0};
    vecs[13] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd1,1'b0,16'h8882,4'd0,1'b0};
    vecs[14] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd1,1'b1,16'hA081,4'd1,1'b0};
    vecs[15] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd2,1'b0,16'hA081,4'd1,1'b0};
    vecs[16] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd2,1'b0,16'hA081,4'd1,1'b0};
    vecs[17] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd2,1'b1,16'h40A0,4'd2,1'b0};
    vecs[18] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd3,1'b0,16'h40A0,4'd2,1'b0};
    vecs[19] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd3,1'b0,16'h40A0,4'd2,1'b0};
    vecs[20] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd3,1'b0,16'h40A0,4'd2,1'b1};
    vecs[21] = '{1'b1,1'b0,4'd0,16'h0000,1'b0,4'd0,1'b1, 1'b0,1'b0,4'd3,1'b0,16'h40A0,4'd2,1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 32'({ld_ack, mem_wren, mem_address, ir_valid, ir, ir_pc, halted}), 32'(0));
    rst = 1'b0;

    // Download and straight-line fetch ending on a NOP halt
    for (int k = 0; k < 22; k++) begin
      run = vecs[k].run;  ld_req = vecs[k].ld_req; ld_addr = vecs[k].ld_addr;
      ld_data = vecs[k].ld_data; br = vecs[k].br; br_tgt = vecs[k].br_tgt; rdy = vecs[k].rdy;
      smp();
      got_o = {ld_ack, mem_wren, mem_address, ir_valid, ir, ir_pc, halted};
      exp_o = {vecs[k].ack, vecs[k].wren, vecs[k].addr, vecs[k].ivld, vecs[k].ir, vecs[k].irpc, vecs[k].halted};
      if (got_o !== exp_o) $display("FAIL vec[%0d] detail: got %h expected %h", k, got_o, exp_o);
      chk($sformatf("vec[%0d]", k), 32'(got_o), 32'(exp_o));
      nxt();
    end
    ref_mem[0] = 16'h8882; ref_mem[1] = 16'hA081; ref_mem[2] = 16'h40A0; ref_mem[3] = 16'h0000;

    // Leave HALT by dropping Run
    run = 1'b0;
    nxt();
    smp();
    chk("halt_exit_halted", 32'(halted), 32'(0));
    chk("halt_exit_pc", 32'(mem_address), 32'(3));
    nxt();

    // Decode stall: everything holds while Ir_Ready is low
    br = 1'b1; br_tgt = 4'd0;
    nxt();
    br = 1'b0; run = 1'b1; rdy = 1'b0;
    wait_valid(ok);
    chk("stall_ir", 32'(ir), 32'(16'h8882));
    chk("stall_irpc", 32'(ir_pc), 32'(0));
    for (int i = 0; i < 5; i++) begin
      nxt();
      smp();
      chk("stall_hold", 32'({ir_valid, ir, ir_pc, mem_address}), 32'({1'b1, 16'h8882, 4'd0, 4'd0}));
    end
    rdy = 1'b1;
    nxt();
    smp();
    chk("stall_release_addr", 32'(mem_address), 32'(1));
    chk("stall_release_vld", 32'(ir_valid), 32'(0));
    run = 1'b0;
    nxt();

    // Redirect while the read of address 0 is in flight
    br = 1'b1; br_tgt = 4'd0;
    nxt();
    br = 1'b0; run = 1'b1;
    nxt();
    nxt();
    smp();
    chk("br_wait_addr", 32'({ir_valid, mem_address}), 32'({1'b0, 4'd0}));
    br = 1'b1; br_tgt = 4'd2;
    nxt();
    br = 1'b0;
    smp();
    chk("br_flush", 32'({ir_valid, mem_address}), 32'({1'b0, 4'd2}));
    nxt();
    wait_valid(ok);
    chk("br_target_irpc", 32'(ir_pc), 32'(2));
    chk("br_target_ir", 32'(ir), 32'(16'h40A0));
    run = 1'b0; rdy = 1'b0;
    nxt();

    // PC wrap from 15 to 0
    load(4'd15, 16'h40A0);
    br = 1'b1; br_tgt = 4'd15;
    nxt();
    br = 1'b0; run = 1'b1; rdy = 1'b0;
    nxt();
    wait_valid(ok);
    chk("wrap_irpc15", 32'({ir, ir_pc}), 32'({16'h40A0, 4'd15}));
    rdy = 1'b1;
    nxt();
    rdy = 1'b0;
    wait_valid(ok);
    chk("wrap_irpc0", 32'({ir, ir_pc}), 32'({16'h8882, 4'd0}));
    rdy = 1'b1;
    nxt();
    rdy = 1'b0;

    // Loader blocked during fetch; Run dropped in HOLD; refetch on resume
    ld_req = 1'b1; ld_addr = 4'd5; ld_data = 16'h1234;
    smp();
    chk("ld_blocked_issue", 32'(ld_ack), 32'(0));
    nxt();
    smp();
    chk("ld_blocked_wait", 32'(ld_ack), 32'(0));
    nxt();
    smp();
    chk("hold_irpc1", 32'({ld_ack, ir_valid, ir_pc, ir}), 32'({1'b0, 1'b1, 4'd1, 16'hA081}));
    run = 1'b0;
    nxt();
    smp();
    chk("run_drop", 32'({ld_ack, ir_valid, mem_address}), 32'({1'b0, 1'b0, 4'd1}));
    nxt();
    smp();
    chk("ld_after_idle", 32'({ld_ack, mem_wren, mem_address}), 32'({1'b1, 1'b1, 4'd5}));
    ld_req = 1'b0;
    ref_mem[5] = 16'h1234;
    nxt();
    smp();
    chk("pc_kept", 32'(mem_address), 32'(1));
    run = 1'b1;
    nxt();
    wait_valid(ok);
    chk("refetch", 32'({ir, ir_pc}), 32'({16'hA081, 4'd1}));

    // Async reset in the middle of a LOAD entered from HALT
    br = 1'b1; br_tgt = 4'd3;
    nxt();
    br = 1'b0;
    nxt();
    nxt();
    smp();
    chk("halt_on_nop", 32'({halted, ir_valid, mem_address}), 32'({1'b1, 1'b0, 4'd3}));
    ld_req = 1'b1; ld_addr = 4'd7; ld_data = 16'h5555;
    nxt();
    smp();
    chk("load_from_halt", 32'({ld_ack, mem_wren, halted}), 32'({1'b1, 1'b1, 1'b1}));
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 32'({ld_ack, mem_wren, ir_valid, halted, ir, ir_pc, mem_address}), 32'(0));
    run = 1'b0; ld_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    smp();
    chk("post_reset", 32'({ld_ack, mem_wren, halted, mem_address}), 32'(0));
    nxt();
    load(4'd7, 16'h5555);

    // Randomized fetch against the PC/memory model
    for (int a = 0; a < 16; a++) load(4'(a), 16'($urandom_range(1, 16'hFFFF)));
    exp_pc  = 4'd0;
    accepts = 0;
    for (int c = 0; c < 3000; c++) begin
      run    = ($urandom_range(0, 9) != 0);
      rdy    = 1'($urandom_range(0, 1));
      br     = ($urandom_range(0, 19) == 0);
      br_tgt = 4'($urandom_range(0, 15));
      smp();
      if (ir_valid) begin
        chk("rand_irpc", 32'(ir_pc), 32'(exp_pc));
        chk("rand_ir", 32'(ir), 32'(ref_mem[exp_pc]));
      end
      if (ld_ack || mem_wren || halted)
        chk("rand_no_load_halt", 32'({ld_ack, mem_wren, halted}), 32'(0));
      if (br) exp_pc = br_tgt;
      else if (run && ir_valid && rdy) begin
        exp_pc = exp_pc + 4'd1;
        accepts++;
      end
      nxt();
    end
    br = 1'b0;
    chk("rand_progress", 32'(accepts > 100), 32'(1));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
Name: instr_fetch_ctrl

Overview:
Sequencer for the 16x16 synchronous-read instruction memory. Owns the program counter, issues reads, absorbs the 1-cycle read latency, and presents each fetched word to decode over a valid/ready handshake. Also arbitrates a loader write port (program download) against fetch, handles branch redirects, and halts on an all-zero word (NOP).

Parameters:
ADDR_W, 4, instruction memory address width (16 words)
DATA_W, 16, instruction word width
HALT_ON_NOP, 1, 1 = a fetched 16'h0000 halts fetch; 0 = NOP is passed to decode like any other word

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
Run  in  1  level; 1 = fetch enabled
Ld_Req  in  1  loader write request, level, held until Ld_Ack
Ld_Addr  in  ADDR_W  loader write address, stable while Ld_Req
Ld_Data  in  DATA_W  loader write data, stable while Ld_Req
Ld_Ack  out  1  write performed this cycle
Br_Valid  in  1  1-cycle redirect strobe
Br_Target  in  ADDR_W  redirect address
Ir_Valid  out  1  Ir/Ir_Pc hold a valid instruction
Ir_Ready  in  1  decode accepts
Ir  out  DATA_W  fetched instruction
Ir_Pc  out  ADDR_W  address Ir was fetched from
Halted  out  1  fetch stopped on NOP
Mem_Wren  out  1  to memory Wren
Mem_Address  out  ADDR_W  to memory Address
Mem_Din  out  DATA_W  to memory Din
Mem_Q  in  DATA_W  from memory Q (valid the cycle after address is presented)

Behaviour:
- Reset (async, immediate, no clock edge): state IDLE, PC=0, Ir=0, Ir_Pc=0, Ir_Valid=0, Halted=0; therefore Mem_Wren=0, Ld_Ack=0, Mem_Address=0.
- Mem_Wren = Ld_Ack = (state==LOAD); Mem_Address = Ld_Addr in LOAD, else PC; Mem_Din = Ld_Data always.
- States:
  - IDLE: Ld_Req -> LOAD (return IDLE); else Br_Valid -> PC<=Br_Target, stay IDLE; else Run -> ISSUE.
  - ISSUE: address=PC, Wren=0 -> WAIT.
  - WAIT: Mem_Q valid. If HALT_ON_NOP and Mem_Q==0 -> HALT, Halted<=1, PC unchanged. Else Ir<=Mem_Q, Ir_Pc<=PC, Ir_Valid<=1 -> HOLD.
  - HOLD: Ir_Valid=1, Ir/Ir_Pc stable. On Ir_Valid & Ir_Ready edge: Ir_Valid<=0, PC<=PC+1 -> ISSUE.
  - HALT: Ld_Req -> LOAD (return HALT); Br_Valid -> PC<=Br_Target, Halted<=0 -> ISSUE (Br wins over Ld; Ld retried since level-held); !Run -> Halted<=0 -> IDLE.
  - LOAD: one write cycle, Ld_Ack=1 -> saved return state. Br_Valid ignored.
- Priority in ISSUE/WAIT/HOLD: Br_Valid > !Run > normal progress.
  - Br_Valid: PC<=Br_Target, Ir_Valid<=0 (flush, any in-flight read discarded) -> ISSUE.
  - !Run: Ir_Valid<=0, PC unchanged -> IDLE; discarded word is refetched on next Run.
- Ld_Req honoured only in IDLE/HALT; while fetching, Ld_Ack stays 0. Back-to-back loads: 2 cycles per word (LOAD, IDLE).
- Throughput: 3 cycles/instruction with Ir_Ready held 1. Fetch-to-valid latency: Ir_Valid rises 2 edges after entering ISSUE.
- PC arithmetic: ADDR_W-bit, 15+1 wraps to 0; no overflow flag.
- Ir_Ready without Ir_Valid: no effect.

Test Plan:
1. Run=0; load mem[0]=16'h8882, mem[1]=16'hA081, mem[2]=16'h40A0, mem[3]=16'h0000 (Ld_Ack one cycle each, Mem_Wren only then); Run=1, Ir_Ready=1 -> Ir/Ir_Pc = 8882/0, A081/1, 40A0/2, then Halted=1, no Ir_Valid for 0000, PC=3.
2. Ir_Ready=0 for 5 cycles while Ir_Valid=1 -> Ir, Ir_Pc, Mem_Address, PC constant; Ready=1 -> next address issued the following cycle.
3. Br_Valid pulse with Br_Target=2 in WAIT of address 0 -> that word never presented, Ir_Valid=0, next Ir=40A0, Ir_Pc=2.
4. mem[15]=16'h40A0, mem[0]=16'h8882, Br to 15 -> Ir_Pc 15 then 0 (wrap).
5. Run dropped in HOLD at Ir_Pc=1 -> Ir_Valid 0 next cycle, PC=1; Ld_Req asserted during fetch got no Ack until IDLE; Run=1 -> A081 refetched at Ir_Pc=1.
6. Reset asserted mid-LOAD between clock edges -> Mem_Wren, Ld_Ack, Ir_Valid, Halted fall immediately; after release PC=0, state IDLE.
